alu_cmd_ctrl: RTL

Command-side controller for the 32-bit registered ALU. It accepts operation commands over a valid/ready handshake and holds the operand register file. It drives operands and opcode into the ALU, captures the registered result and flags one cycle later, writes the result back, and returns a response over a second valid/ready handshake. It sits between the command source (test sequencer or future decode stage) and the ALU, which is wired alongside it at the level above.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_regfile.sv | 36 +++
 rtl/alu_cmd_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command controller: opcodes, flag layout,
// FSM state encoding and small flag helpers.
package alu_pkg;

    localparam logic [3:0] OP_SHL_A = 4'd0;
    localparam logic [3:0] OP_SHL_B = 4'd1;
    localparam logic [3:0] OP_SHR_A = 4'd2;
    localparam logic [3:0] OP_SHR_B = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOT_A = 4'd7;
    localparam logic [3:0] OP_ADD   = 4'd8;
    localparam logic [3:0] OP_SUB   = 4'd9;
    localparam logic [3:0] OP_READ  = 4'd14;
    localparam logic [3:0] OP_LOAD  = 4'd15;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Pack individual flags into the {negative, zero, carry} response vector.
    function automatic logic [2:0] make_flags(input logic n, input logic z, input logic c);
        logic [2:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        return f;
    endfunction

    // Flags for values that bypass the ALU (LOAD immediate, READ of a register).
    function automatic logic [2:0] value_flags(input logic [31:0] v);
        return make_flags(v[31], v == 32'd0, 1'b0);
    endfunction

    // Everything except READ and LOAD goes through the ALU, reserved codes included.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op != OP_READ) && (op != OP_LOAD);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: NREG x 32 bits, two combinational read ports,
// one synchronous write port, synchronous clear on reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int NREG = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] rd_addr_a,
    input  logic [RW-1:0] rd_addr_b,
    output logic [31:0]   rd_data_a,
    output logic [31:0]   rd_data_b,
    input  logic          wr_en,
    input  logic [RW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    logic [31:0] regs [NREG];

    // Single write port; reset clears every entry so reads after reset see zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for the registered ALU: accepts commands, drives
// operands into the ALU, writes results back and returns responses.
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter  int NREG = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [RW-1:0] cmd_dst,
    input  logic [RW-1:0] cmd_src_a,
    input  logic [RW-1:0] cmd_src_b,
    input  logic [31:0]   cmd_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic [2:0]    rsp_flags,
    output logic [15:0]   op_count,
    output logic [31:0]   alu_port_A,
    output logic [31:0]   alu_port_B,
    output logic [3:0]    alu_opcode,
    input  logic [31:0]   alu_result,
    input  logic          alu_negative,
    input  logic          alu_zero,
    input  logic          alu_carry
);

    state_t        state;
    state_t        next_state;
    logic [RW-1:0] dst_q;
    logic [31:0]   rd_a;
    logic [31:0]   rd_b;
    logic          wr_en;
    logic [RW-1:0] wr_addr;
    logic [31:0]   wr_data;

    alu_regfile #(.NREG(NREG)) regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (cmd_src_a),
        .rd_addr_b (cmd_src_b),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // State register; reset abandons any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; LOAD/READ skip straight to the response.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    next_state = is_alu_op(cmd_op) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE:   next_state = ST_CAPTURE;
            ST_CAPTURE: next_state = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    // Register file write: LOAD writes at acceptance, ALU ops write back in CAPTURE.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cmd_dst;
        wr_data = cmd_imm;
        if (state == ST_IDLE && cmd_valid && cmd_op == OP_LOAD) begin
            wr_en = 1'b1;
        end else if (state == ST_CAPTURE) begin
            wr_en   = 1'b1;
            wr_addr = dst_q;
            wr_data = alu_result;
        end
    end

    // Operand, response and counter registers; ALU outputs only change on ALU-op acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_port_A <= '0;
            alu_port_B <= '0;
            alu_opcode <= '0;
            dst_q      <= '0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (is_alu_op(cmd_op)) begin
                            alu_port_A <= rd_a;
                            alu_port_B <= rd_b;
                            alu_opcode <= cmd_op;
                            dst_q      <= cmd_dst;
                        end else if (cmd_op == OP_LOAD) begin
                            rsp_data  <= cmd_imm;
                            rsp_flags <= value_flags(cmd_imm);
                        end else begin
                            rsp_data  <= rd_a;
                            rsp_flags <= value_flags(rd_a);
                        end
                    end
                end
                ST_CAPTURE: begin
                    rsp_data  <= alu_result;
                    rsp_flags <= make_flags(alu_negative, alu_zero, alu_carry);
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
